// File: rtl/arena_scanner_if.sv
// Valid/ready beat stream carrying one arena cell (row, col, occupancy) per beat.
interface arena_scanner_if #(
   parameter int RC_W = 4
);
   logic            out_valid;
   logic            out_ready;
   logic [RC_W-1:0] out_row;
   logic [RC_W-1:0] out_col;
   logic            out_cell;

   modport master (
      output out_valid,
      output out_row,
      output out_col,
      output out_cell,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_row,
      input  out_col,
      input  out_cell,
      output out_ready
   );
endinterface

// File: rtl/arena_scanner.sv
// Snapshots the arena occupancy map on start and streams its cells in raster order.
// Define ARENA_SCAN_SKIP_BORDER_EN to emit only the interior cells.
module arena_scanner #(
   parameter int ROWS  = 10,
   parameter int COLS  = 10,
   parameter int RC_W  = 4,
   parameter int CNT_W = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ROWS*COLS-1:0] arena,
   input  logic                 start,
   arena_scanner_if.master      scan_out,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     wall_count
);

   localparam int N     = ROWS * COLS;
   localparam int IDX_W = $clog2(N);

`ifdef ARENA_SCAN_SKIP_BORDER_EN
   localparam int ROW_FIRST = 1;
   localparam int ROW_LAST  = ROWS - 2;
   localparam int COL_FIRST = 1;
   localparam int COL_LAST  = COLS - 2;
`else
   localparam int ROW_FIRST = 0;
   localparam int ROW_LAST  = ROWS - 1;
   localparam int COL_FIRST = 0;
   localparam int COL_LAST  = COLS - 1;
`endif

   localparam logic [RC_W-1:0]  ROW_FIRST_V = RC_W'(ROW_FIRST);
   localparam logic [RC_W-1:0]  ROW_LAST_V  = RC_W'(ROW_LAST);
   localparam logic [RC_W-1:0]  COL_FIRST_V = RC_W'(COL_FIRST);
   localparam logic [RC_W-1:0]  COL_LAST_V  = RC_W'(COL_LAST);
   localparam logic [IDX_W-1:0] IDX_FIRST   = IDX_W'(ROW_FIRST * COLS + COL_FIRST);
   // Jump from the last emitted column of one row to the first emitted column of the next.
   localparam logic [IDX_W-1:0] IDX_WRAP    = IDX_W'(COLS - COL_LAST + COL_FIRST);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    snap_q, snap_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [RC_W-1:0] row_q, row_d;
   logic [RC_W-1:0] col_q, col_d;
   logic            cell_q, cell_d;
   logic            valid_q, valid_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [CNT_W-1:0] wall_q, wall_d;

   logic             accept_s;
   logic             last_s;
   logic             row_end_s;
   logic [IDX_W-1:0] next_idx_s;

   always_comb begin
      accept_s   = valid_q && scan_out.out_ready;
      row_end_s  = (col_q == COL_LAST_V);
      last_s     = (row_q == ROW_LAST_V) && row_end_s;
      next_idx_s = row_end_s ? (idx_q + IDX_WRAP) : (idx_q + IDX_W'(1));
   end

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      idx_d   = idx_q;
      row_d   = row_q;
      col_d   = col_q;
      cell_d  = cell_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      wall_d  = wall_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SCAN;
               snap_d  = arena;
               idx_d   = IDX_FIRST;
               row_d   = ROW_FIRST_V;
               col_d   = COL_FIRST_V;
               cell_d  = arena[IDX_FIRST];
               valid_d = 1'b1;
               busy_d  = 1'b1;
               wall_d  = {CNT_W{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SCAN: begin
            if (accept_s) begin
               wall_d = wall_q + CNT_W'(cell_q);
               if (last_s) begin
                  // Coordinates stay on the final cell so they remain readable in IDLE.
                  state_d = S_DONE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else if (row_end_s) begin
                  row_d  = row_q + RC_W'(1);
                  col_d  = COL_FIRST_V;
                  idx_d  = next_idx_s;
                  cell_d = snap_q[next_idx_s];
               end else begin
                  col_d  = col_q + RC_W'(1);
                  idx_d  = next_idx_s;
                  cell_d = snap_q[next_idx_s];
               end
            end else begin
               state_d = S_SCAN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         snap_q  <= {N{1'b0}};
         idx_q   <= {IDX_W{1'b0}};
         row_q   <= {RC_W{1'b0}};
         col_q   <= {RC_W{1'b0}};
         cell_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wall_q  <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         idx_q   <= idx_d;
         row_q   <= row_d;
         col_q   <= col_d;
         cell_q  <= cell_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wall_q  <= wall_d;
      end
   end

   assign scan_out.out_valid = valid_q;
   assign scan_out.out_row   = row_q;
   assign scan_out.out_col   = col_q;
   assign scan_out.out_cell  = cell_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign wall_count         = wall_q;

endmodule

// File: tb/tb_arena_scanner.sv
// Directed bench for arena_scanner: raster order, backpressure, snapshot isolation, restart rules.
module tb_arena_scanner;

   localparam int ROWS  = 10;
   localparam int COLS  = 10;
   localparam int RC_W  = 4;
   localparam int CNT_W = 7;
   localparam int N     = ROWS * COLS;

`ifdef ARENA_SCAN_SKIP_BORDER_EN
   localparam int NBEATS = 64;
   localparam int WALLS  = 14;
   localparam int R0 = 1, C0 = 1, RL = 8, CL = 8;
   localparam int NHAND = 3;
   int         hand_b [NHAND] = '{0, 2, 63};
   logic [8:0] hand_v [NHAND] = '{{4'd1, 4'd1, 1'b0}, {4'd1, 4'd3, 1'b1}, {4'd8, 4'd8, 1'b0}};
`else
   localparam int NBEATS = 100;
   localparam int WALLS  = 50;
   localparam int R0 = 0, C0 = 0, RL = 9, CL = 9;
   localparam int NHAND = 4;
   int         hand_b [NHAND] = '{0, 11, 13, 99};
   logic [8:0] hand_v [NHAND] = '{{4'd0, 4'd0, 1'b1}, {4'd1, 4'd1, 1'b0},
                                  {4'd1, 4'd3, 1'b1}, {4'd9, 4'd9, 1'b1}};
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [N-1:0]     arena;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] wall_count;
   logic [N-1:0]     default_arena;

   int n_checks = 0;
   int n_fail   = 0;
   int blocks [14] = '{13, 17, 24, 32, 34, 38, 46, 51, 56, 57, 62, 63, 76, 84};

   arena_scanner_if #(.RC_W(RC_W)) bus ();

   arena_scanner #(.ROWS(ROWS), .COLS(COLS), .RC_W(RC_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .arena      (arena),
      .start      (start),
      .scan_out   (bus),
      .busy       (busy),
      .done       (done),
      .wall_count (wall_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [8:0] fields();
      return {bus.out_row, bus.out_col, bus.out_cell};
   endfunction

   task automatic check_all_zero(input string tag);
      check_eq(tag, 32'({fields(), bus.out_valid, busy, done, wall_count}), 32'd0);
   endtask

   // One scan: alt_ready toggles out_ready, iso edits arena at beat 5,
   // busy_start pulses start at beat 40, abort_at asserts rst_n at that beat (-1 = never).
   task automatic run_scan(input bit alt_ready, input bit iso, input bit busy_start, input int abort_at);
      int b;
      int cyc;
      int r;
      int c;
      bit held;
      logic [8:0] prev_f;
      logic [8:0] exp_f;
      b = 0;
      cyc = 0;
      held = 1'b0;
      prev_f = 9'd0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("busy_after_start", 32'(busy), 32'd1);
      check_eq("wall_cleared", 32'(wall_count), 32'd0);
      while (b < NBEATS && cyc < 1000) begin
         check_eq("valid", 32'(bus.out_valid), 32'd1);
         if (bus.out_valid !== 1'b1) break;
         r = R0 + b / (CL - C0 + 1);
         c = C0 + b % (CL - C0 + 1);
         exp_f = {r[3:0], c[3:0], default_arena[r * COLS + c]};
         check_eq("beat", 32'(fields()), 32'(exp_f));
         if (held) check_eq("hold", 32'(fields()), 32'(prev_f));
         for (int k = 0; k < NHAND; k++)
            if (hand_b[k] == b && !held) check_eq("hand_beat", 32'(fields()), 32'(hand_v[k]));
         if (b == abort_at) begin
            rst_n = 1'b0;
            #1;
            check_all_zero("abort_reset");
            return;
         end
         if (iso && b == 5) begin
            arena[55] = 1'b1;
            arena[13] = 1'b0;
         end
         if (busy_start && b == 40 && !held) start = 1'b1;
         bus.out_ready = alt_ready ? cyc[0] : 1'b1;
         held = !bus.out_ready;
         prev_f = fields();
         @(posedge clk); #1;
         start = 1'b0;
         if (!held) b++;
         cyc++;
      end
      bus.out_ready = 1'b1;
      check_eq("beat_count", 32'(b), 32'(NBEATS));
      check_eq("done_pulse", 32'({done, busy, bus.out_valid}), 32'b110);
      check_eq("wall_count", 32'(wall_count), 32'(WALLS));
      @(posedge clk); #1;
      check_eq("done_clear", 32'({done, busy, bus.out_valid}), 32'b000);
      check_eq("idle_hold", 32'({bus.out_row, bus.out_col, wall_count}),
               32'({4'(RL), 4'(CL), 7'(WALLS)}));
   endtask

   initial begin
      default_arena = {N{1'b0}};
      for (int i = 0; i < ROWS; i++) begin
         for (int j = 0; j < COLS; j++) begin
            if (i == 0 || i == ROWS - 1 || j == 0 || j == COLS - 1)
               default_arena[i * COLS + j] = 1'b1;
         end
      end
      foreach (blocks[i]) default_arena[blocks[i]] = 1'b1;

      rst_n = 1'b0;
      start = 1'b0;
      arena = default_arena;
      bus.out_ready = 1'b1;
      #12;
      check_all_zero("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_all_zero("idle_after_reset");

      run_scan(1'b0, 1'b0, 1'b0, -1);
      run_scan(1'b1, 1'b0, 1'b1, -1);
      run_scan(1'b0, 1'b1, 1'b0, -1);
      arena = default_arena;

      run_scan(1'b0, 1'b0, 1'b0, 60);
      @(posedge clk); #1;
      check_all_zero("held_in_reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_all_zero("idle_after_abort");

      run_scan(1'b0, 1'b0, 1'b0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/arena_scanner.md
Name: arena_scanner

Overview:
- Reader side of the 100-bit arena occupancy map (row-major, bit index = row*COLS + col, 1 = wall/block, 0 = free).
- On a start pulse, snapshots the map and streams every cell out in raster order over a valid/ready interface to downstream consumers (renderer, serializer, debug dump).
- Counts solid cells and signals completion.

Parameters:
- ROWS, 10, number of arena rows.
- COLS, 10, number of arena columns.
- RC_W, 4, width of row/col coordinate outputs; must satisfy 2^RC_W >= max(ROWS, COLS).
- CNT_W, 7, width of solid-cell counter; must satisfy 2^CNT_W > ROWS*COLS.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arena  in  ROWS*COLS  live occupancy map.
- start  in  1  single-cycle scan request.
- out_ready  in  1  downstream accepts beat.
- out_valid  out  1  beat present.
- out_row  out  RC_W  row of current cell.
- out_col  out  RC_W  column of current cell.
- out_cell  out  1  occupancy bit of current cell (from snapshot).
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle pulse after final beat accepted.
- wall_count  out  CNT_W  number of accepted beats with out_cell=1 in the current/last scan.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, out_row=0, out_col=0, out_cell=0, busy=0, done=0, wall_count=0, snapshot=0. Applies immediately, including mid-scan; the scan is abandoned, not resumed.
- FSM states:
  - IDLE: start=1 at edge k -> snapshot<=arena, row=col=0, wall_count<=0, go SCAN. out_valid=1 from cycle k+1 (latency 1).
  - SCAN: out_valid=1; out_cell=snapshot[row*COLS+col].
    - Beat accepted when out_valid && out_ready. On accept: wall_count += out_cell; col++. When col==COLS-1, col wraps to 0 and row++.
    - Accept of last cell (ROWS-1, COLS-1) -> DONE, out_valid<=0.
  - DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Handshake: while out_valid && !out_ready, out_row/out_col/out_cell held stable. out_valid never drops before acceptance in SCAN.
- start while busy: ignored, no restart, no effect on counters.
- arena changes after snapshot do not affect the current scan.
- Throughput: one beat/cycle with out_ready held high; full scan = ROWS*COLS cycles of out_valid.
- wall_count holds its final value through IDLE until the next accepted start.
- out_row/out_col hold the last cell's coordinates in IDLE after a scan.

Optional Feature:
- ARENA_SCAN_SKIP_BORDER_EN defined: only interior cells (rows 1..ROWS-2, cols 1..COLS-2) are emitted.
  - Scan starts at (1,1), wraps col COLS-2 -> 1 with row++, ends after (ROWS-2, COLS-2).
  - (ROWS-2)*(COLS-2) beats; wall_count counts interior only.
- Not defined: full ROWS*COLS raster as above.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> all outputs 0 immediately, before next edge; state IDLE.
- Default arena (border all 1; blocks at indices 13,17,24,32,34,38,46,51,56,57,62,63,76,84), out_ready=1, start pulse -> 100 consecutive beats beginning cycle after start:
  - beat 0 = (0,0,1); beat 11 = (1,1,0); beat 13 = (1,3,1); beat 99 = (9,9,1).
  - done pulses the cycle after beat 99; wall_count=50.
- Backpressure: out_ready alternating 0/1 -> fields stable during ready=0 cycles; same 100-beat sequence over ~200 cycles; wall_count=50.
- Snapshot isolation: set arena bit 55 and clear bit 13 at beat 5 -> beat 13 still out_cell=1, beat 55 out_cell=0, wall_count=50.
- Restart rules:
  - start at beat 40 -> ignored, sequence continues to 99.
  - rst_n low at beat 60 -> all outputs 0.
  - new start after release -> fresh scan from (0,0), wall_count restarts at 0.
- With ARENA_SCAN_SKIP_BORDER_EN: default arena -> 64 beats, first (1,1,0), last (8,8,0), wall_count=14, done after beat 63.
